sd_sdp_rx: RTL

- Master-side receiver and parser for slave response messages.
- Message layout: MARKER_SLAVE, STATUS, N1 (length high byte), N2 (length low byte), then N payload bytes.
- Sits between the channel decoder's byte output and the master's host logic.
- Validates the header, streams the payload, reports end-of-message or a coded error, and resynchronises on the next marker.

---
 rtl/sd_sdp_rx_pkg.sv | 30 +++
 rtl/sd_sdp_rx_timeout.sv | 32 +++
 rtl/sd_sdp_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_sdp_rx_pkg.sv
// Shared definitions for the slave-response receiver: marker, length limit,
// STATUS bit positions, error codes and the parser state encoding.
package sd_sdp_rx_pkg;

    localparam logic [7:0]  MARKER_SLAVE  = 8'hA5;
    localparam int unsigned S_DP_LEN      = 1024;
    localparam int unsigned TO_CYCLES_DEF = 2048;
    localparam int unsigned LEN_W         = 11;

    // STATUS byte bit indices
    localparam int unsigned STAT_ERR  = 0;
    localparam int unsigned STAT_SREQ = 1;
    localparam int unsigned STAT_BUSY = 2;
    localparam int unsigned STAT_DPS  = 4;

    // err_code values
    localparam logic [1:0] ERR_RX       = 2'd0;
    localparam logic [1:0] ERR_OVF      = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StGetStatus = 3'd1,
        StGetN1     = 3'd2,
        StGetN2     = 3'd3,
        StGetPl     = 3'd4
    } state_t;

endpackage

// File: rtl/sd_sdp_rx_timeout.sv
// Inter-byte idle counter. Counts while enabled, restarts on clear, and
// pulses expire in the cycle whose increment would reach LIMIT.
module sd_sdp_rx_timeout #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LIMIT = 2048
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    // clear dominates, so a byte arriving in the expiry cycle suppresses it
    assign expire = enable && !clear && (count_q == LAST);

    // idle-cycle counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear || expire) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sd_sdp_rx.sv
// Master-side receiver for slave response messages:
// MARKER, STATUS, N1, N2, then N payload bytes. Validates the header,
// streams the payload and reports completion or a coded error.
module sd_sdp_rx
    import sd_sdp_rx_pkg::*;
#(
    parameter logic [7:0]  MARKER    = MARKER_SLAVE,
    parameter int unsigned MAX_LEN   = S_DP_LEN,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       d,
    input  logic             d_rdy,
    input  logic             rx_err,
    input  logic             abort,
    output logic [7:0]       status,
    output logic [LEN_W-1:0] pl_len,
    output logic             hdr_vld,
    output logic [7:0]       pl_q,
    output logic             pl_q_rdy,
    output logic             msg_end,
    output logic             msg_err,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int unsigned      TO_W      = $clog2(TO_CYCLES) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       stat_q, stat_d;       // STATUS of the message in flight
    logic [2:0]       n1_q, n1_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;         // payload bytes still expected
    logic [7:0]       status_q, status_d;
    logic [LEN_W-1:0] pl_len_q, pl_len_d;
    logic [7:0]       pl_q_q, pl_q_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             hdr_vld_q, hdr_vld_d;
    logic             pl_q_rdy_q, pl_q_rdy_d;
    logic             msg_end_q, msg_end_d;
    logic             msg_err_q, msg_err_d;
    logic             busy_q;

    logic             err_hit;
    logic [1:0]       err_val;
    logic [LEN_W-1:0] len;
    logic             len_zero;
    logic             to_clear;
    logic             to_enable;
    logic             to_expire;

    assign to_enable = (state_q != StIdle);
    assign to_clear  = d_rdy || abort || (state_q == StIdle);

    sd_sdp_rx_timeout #(
        .WIDTH (TO_W),
        .LIMIT (TO_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (to_clear),
        .enable (to_enable),
        .expire (to_expire)
    );

    // next-state and output decode; abort > rx_err > byte > timeout
    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        n1_d       = n1_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        pl_len_d   = pl_len_q;
        pl_q_d     = pl_q_q;
        err_code_d = err_code_q;
        hdr_vld_d  = 1'b0;
        pl_q_rdy_d = 1'b0;
        msg_end_d  = 1'b0;
        msg_err_d  = 1'b0;
        err_hit    = 1'b0;
        err_val    = ERR_RX;
        len        = {n1_q, d};
        len_zero   = (len == '0);

        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if ((state_q != StIdle) && rx_err) begin
            err_hit = 1'b1;
            err_val = ERR_RX;
        end else if (d_rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (d == MARKER) begin
                        state_d = StGetStatus;
                    end
                end
                StGetStatus: begin
                    stat_d  = d;
                    state_d = StGetN1;
                end
                StGetN1: begin
                    if (d[7:3] != 5'd0) begin
                        err_hit = 1'b1;
                        err_val = ERR_OVF;
                    end else begin
                        n1_d    = d[2:0];
                        state_d = StGetN2;
                    end
                end
                StGetN2: begin
                    if (len > MAX_LEN_L) begin
                        err_hit = 1'b1;
                        err_val = ERR_OVF;
                    end else if (stat_q[STAT_DPS] == len_zero) begin
                        // DPS must be set exactly when a payload follows
                        err_hit = 1'b1;
                        err_val = ERR_MISMATCH;
                    end else if (stat_q[STAT_ERR] && !len_zero) begin
                        err_hit = 1'b1;
                        err_val = ERR_MISMATCH;
                    end else begin
                        hdr_vld_d = 1'b1;
                        status_d  = stat_q;
                        pl_len_d  = len;
                        if (len_zero) begin
                            msg_end_d = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            cnt_d   = len;
                            state_d = StGetPl;
                        end
                    end
                end
                StGetPl: begin
                    pl_q_d     = d;
                    pl_q_rdy_d = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        msg_end_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (to_expire) begin
            err_hit = 1'b1;
            err_val = ERR_TIMEOUT;
        end

        if (err_hit) begin
            msg_err_d  = 1'b1;
            err_code_d = err_val;
            state_d    = StIdle;
            cnt_d      = '0;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            stat_q     <= '0;
            n1_q       <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            pl_len_q   <= '0;
            pl_q_q     <= '0;
            err_code_q <= '0;
            hdr_vld_q  <= 1'b0;
            pl_q_rdy_q <= 1'b0;
            msg_end_q  <= 1'b0;
            msg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            n1_q       <= n1_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            pl_len_q   <= pl_len_d;
            pl_q_q     <= pl_q_d;
            err_code_q <= err_code_d;
            hdr_vld_q  <= hdr_vld_d;
            pl_q_rdy_q <= pl_q_rdy_d;
            msg_end_q  <= msg_end_d;
            msg_err_q  <= msg_err_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign status   = status_q;
    assign pl_len   = pl_len_q;
    assign hdr_vld  = hdr_vld_q;
    assign pl_q     = pl_q_q;
    assign pl_q_rdy = pl_q_rdy_q;
    assign msg_end  = msg_end_q;
    assign msg_err  = msg_err_q;
    assign err_code = err_code_q;
    assign busy     = busy_q;

endmodule
